// File: rtl/gb_cpu_regfile_if.sv
// Flag type shared with the ALU, plus the register-file port bundle.
// The CPU/datapath side uses the master modport; the register file uses slave.
package gb_cpu_regfile_pkg;
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;
endpackage

interface gb_cpu_regfile_if;
  import gb_cpu_regfile_pkg::*;

  logic [2:0]  rd_a_sel;
  logic [7:0]  rd_a_data;
  logic [2:0]  rd_b_sel;
  logic [7:0]  rd_b_data;

  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;

  alu_flags_t  flags_in;
  logic [3:0]  flags_we;
  alu_flags_t  flags_out;

  logic [1:0]  pair_sel;
  logic [15:0] pair_rd_data;
  logic        pair_wr_en;
  logic [15:0] pair_wr_data;

  logic [1:0]  idu_op;
  logic [1:0]  idu_sel;
  logic [15:0] idu_result;

  logic [15:0] af_data;

  // Write strobes (wr_en, pair_wr_en, flags_we, idu_op inc/dec) are sampled at
  // every rising clk edge with no handshake: the register file is always ready,
  // and a strobe held high for N edges performs N writes.
  modport master (
    output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flags_in, flags_we,
           pair_sel, pair_wr_en, pair_wr_data, idu_op, idu_sel,
    input  rd_a_data, rd_b_data, flags_out, pair_rd_data, idu_result, af_data
  );

  modport slave (
    input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, flags_in, flags_we,
           pair_sel, pair_wr_en, pair_wr_data, idu_op, idu_sel,
    output rd_a_data, rd_b_data, flags_out, pair_rd_data, idu_result, af_data
  );
endinterface

// File: rtl/gb_cpu_regfile.sv
// SM83 register file: A,F,B,C,D,E,H,L and SP, two byte read ports, a pair port,
// and a 16-bit increment/decrement unit that writes back to its own pair.
module gb_cpu_regfile
  import gb_cpu_regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  gb_cpu_regfile_if.slave    rf
);

  localparam logic [2:0] SEL_B = 3'd0;
  localparam logic [2:0] SEL_C = 3'd1;
  localparam logic [2:0] SEL_D = 3'd2;
  localparam logic [2:0] SEL_E = 3'd3;
  localparam logic [2:0] SEL_H = 3'd4;
  localparam logic [2:0] SEL_L = 3'd5;
  localparam logic [2:0] SEL_F = 3'd6;
  localparam logic [2:0] SEL_A = 3'd7;

  localparam logic [1:0] PAIR_BC = 2'd0;
  localparam logic [1:0] PAIR_DE = 2'd1;
  localparam logic [1:0] PAIR_HL = 2'd2;
  localparam logic [1:0] PAIR_SP = 2'd3;

  localparam logic [1:0] IDU_INC = 2'b01;
  localparam logic [1:0] IDU_DEC = 2'b10;

  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  c_q, c_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  e_q, e_d;
  logic [7:0]  h_q, h_d;
  logic [7:0]  l_q, l_d;
  logic [15:0] sp_q, sp_d;
  // Only the upper nibble of F exists; the low nibble is tied to zero on read.
  alu_flags_t  flag_q, flag_d;

  logic [7:0]  f_byte;
  logic [15:0] idu_src;
  logic [15:0] idu_val;
  logic        idu_wr;

  assign f_byte = {flag_q, 4'b0000};

  function automatic logic [7:0] read_byte(input logic [2:0] sel);
    logic [7:0] v;
    v = 8'h00;
    case (sel)
      SEL_B:   v = b_q;
      SEL_C:   v = c_q;
      SEL_D:   v = d_q;
      SEL_E:   v = e_q;
      SEL_H:   v = h_q;
      SEL_L:   v = l_q;
      SEL_F:   v = f_byte;
      default: v = a_q;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] read_pair(input logic [1:0] sel);
    logic [15:0] v;
    v = 16'h0000;
    case (sel)
      PAIR_BC: v = {b_q, c_q};
      PAIR_DE: v = {d_q, e_q};
      PAIR_HL: v = {h_q, l_q};
      default: v = sp_q;
    endcase
    return v;
  endfunction

  always_comb begin
    rf.rd_a_data    = read_byte(rf.rd_a_sel);
    rf.rd_b_data    = read_byte(rf.rd_b_sel);
    rf.pair_rd_data = read_pair(rf.pair_sel);
    rf.flags_out    = flag_q;
    rf.af_data      = {a_q, f_byte};
  end

  always_comb begin
    idu_src = read_pair(rf.idu_sel);
    idu_wr  = 1'b0;
    idu_val = idu_src;
    case (rf.idu_op)
      IDU_INC: begin
        idu_val = idu_src + 16'd1;
        idu_wr  = 1'b1;
      end
      IDU_DEC: begin
        idu_val = idu_src - 16'd1;
        idu_wr  = 1'b1;
      end
      default: begin
        idu_val = idu_src;
        idu_wr  = 1'b0;
      end
    endcase
    rf.idu_result = idu_val;
  end

  // Sources are applied lowest priority first so later assignments win per
  // byte: wr_en, then IDU, then pair write. Flag strobes land after the byte
  // write to F so individual flag bits override it.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    d_d    = d_q;
    e_d    = e_q;
    h_d    = h_q;
    l_d    = l_q;
    sp_d   = sp_q;
    flag_d = flag_q;

    if (rf.wr_en) begin
      case (rf.wr_sel)
        SEL_B:   b_d    = rf.wr_data;
        SEL_C:   c_d    = rf.wr_data;
        SEL_D:   d_d    = rf.wr_data;
        SEL_E:   e_d    = rf.wr_data;
        SEL_H:   h_d    = rf.wr_data;
        SEL_L:   l_d    = rf.wr_data;
        SEL_F:   flag_d = rf.wr_data[7:4];
        default: a_d    = rf.wr_data;
      endcase
    end

    flag_d = (flag_d & ~rf.flags_we) | (rf.flags_in & rf.flags_we);

    if (idu_wr) begin
      case (rf.idu_sel)
        PAIR_BC: {b_d, c_d} = idu_val;
        PAIR_DE: {d_d, e_d} = idu_val;
        PAIR_HL: {h_d, l_d} = idu_val;
        default: sp_d       = idu_val;
      endcase
    end

    if (rf.pair_wr_en) begin
      case (rf.pair_sel)
        PAIR_BC: {b_d, c_d} = rf.pair_wr_data;
        PAIR_DE: {d_d, e_d} = rf.pair_wr_data;
        PAIR_HL: {h_d, l_d} = rf.pair_wr_data;
        default: sp_d       = rf.pair_wr_data;
      endcase
    end
  end

  // Reset values match the DMG boot ROM hand-off state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= 8'h01;
      flag_q <= 4'hB;
      b_q    <= 8'h00;
      c_q    <= 8'h13;
      d_q    <= 8'h00;
      e_q    <= 8'hD8;
      h_q    <= 8'h01;
      l_q    <= 8'h4D;
      sp_q   <= 16'hFFFE;
    end else begin
      a_q    <= a_d;
      flag_q <= flag_d;
      b_q    <= b_d;
      c_q    <= c_d;
      d_q    <= d_d;
      e_q    <= e_d;
      h_q    <= h_d;
      l_q    <= l_d;
      sp_q   <= sp_d;
    end
  end

endmodule
